// File: rtl/mcc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, ALU ops, mux selects.
package mcc_pkg;

  typedef enum logic [2:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111,
    sEXE_BR = 3'b101,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_L   = 3'b100
  } state_t;

  localparam logic [5:0] op_add   = 6'b000000;
  localparam logic [5:0] op_sub   = 6'b000001;
  localparam logic [5:0] op_addiu = 6'b000010;
  localparam logic [5:0] op_and   = 6'b010000;
  localparam logic [5:0] op_andi  = 6'b010001;
  localparam logic [5:0] op_ori   = 6'b010010;
  localparam logic [5:0] op_or    = 6'b010011;
  localparam logic [5:0] op_sll   = 6'b011000;
  localparam logic [5:0] op_slti  = 6'b011100;
  localparam logic [5:0] op_slt   = 6'b100110;
  localparam logic [5:0] op_sw    = 6'b110000;
  localparam logic [5:0] op_lw    = 6'b110001;
  localparam logic [5:0] op_beq   = 6'b110100;
  localparam logic [5:0] op_bne   = 6'b110101;
  localparam logic [5:0] op_bltz  = 6'b110110;
  localparam logic [5:0] op_j     = 6'b111000;
  localparam logic [5:0] op_jr    = 6'b111001;
  localparam logic [5:0] op_jal   = 6'b111010;
  localparam logic [5:0] op_halt  = 6'b111111;

  localparam logic [2:0] alu_add = 3'b000;
  localparam logic [2:0] alu_sub = 3'b001;
  localparam logic [2:0] alu_slt = 3'b011;
  localparam logic [2:0] alu_sll = 3'b100;
  localparam logic [2:0] alu_or  = 3'b101;
  localparam logic [2:0] alu_and = 3'b110;

  localparam logic [1:0] rd_ra = 2'b00;
  localparam logic [1:0] rd_rt = 2'b01;
  localparam logic [1:0] rd_rd = 2'b10;

  localparam logic [1:0] pc_seq = 2'b00;
  localparam logic [1:0] pc_br  = 2'b01;
  localparam logic [1:0] pc_jr  = 2'b10;
  localparam logic [1:0] pc_j   = 2'b11;

  typedef struct packed {
    logic       pcwre;
    logic       irwre;
    logic       insmemrw;
    logic       mrd;
    logic       mwr;
    logic       regwre;
    logic       alusrca;
    logic       alusrcb;
    logic       dbdatasrc;
    logic       wrregdsrc;
    logic       extsel;
    logic [1:0] regdst;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      op_add, op_sub, op_addiu, op_and, op_andi,
      op_ori, op_or, op_sll, op_slti, op_slt: is_alu_op = 1'b1;
      default:                                is_alu_op = 1'b0;
    endcase
  endfunction

  // I-format ALU ops write rt instead of rd
  function automatic logic is_imm_alu(input logic [5:0] op);
    case (op)
      op_addiu, op_andi, op_ori, op_slti: is_imm_alu = 1'b1;
      default:                            is_imm_alu = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      op_sub, op_beq, op_bne, op_bltz: alu_of = alu_sub;
      op_sll:                          alu_of = alu_sll;
      op_or, op_ori:                   alu_of = alu_or;
      op_and, op_andi:                 alu_of = alu_and;
      op_slt, op_slti:                 alu_of = alu_slt;
      default:                         alu_of = alu_add;
    endcase
  endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational control-word decode from (state, op, zero, sign).
// Macro MCC_ILLEGAL_TRAP_EN: unlisted opcodes stall in sID instead of retiring as a NOP.
module mcc_output_decode
  import mcc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output ctrl_t      ctrl
);

  logic taken;

  always_comb begin
    taken = ((op == op_beq) & zero) | ((op == op_bne) & ~zero) | ((op == op_bltz) & sign);
  end

  always_comb begin
    ctrl          = '0;
    ctrl.aluop    = alu_of(op);
    ctrl.alusrca  = (op == op_sll);
    ctrl.alusrcb  = is_imm_alu(op) | (op == op_lw) | (op == op_sw);
    ctrl.extsel   = ~((op == op_andi) | (op == op_ori));
    case (state)
      sIF: begin
        ctrl.irwre    = 1'b1;
        ctrl.insmemrw = 1'b1;
      end
      sID: begin
        if (op == op_j) begin
          ctrl.pcwre = 1'b1;
          ctrl.pcsrc = pc_j;
        end else if (op == op_jal) begin
          ctrl.pcwre  = 1'b1;
          ctrl.pcsrc  = pc_j;
          ctrl.regwre = 1'b1;
          ctrl.regdst = rd_ra;
        end else if (op == op_jr) begin
          ctrl.pcwre = 1'b1;
          ctrl.pcsrc = pc_jr;
        end else if (op != op_halt && !is_alu_op(op) && op != op_beq && op != op_bne &&
                     op != op_bltz && op != op_lw && op != op_sw) begin
`ifdef MCC_ILLEGAL_TRAP_EN
          ctrl.pcwre = 1'b0;
`else
          ctrl.pcwre = 1'b1;
`endif
        end
      end
      sWB_AL: begin
        ctrl.pcwre     = 1'b1;
        ctrl.regwre    = 1'b1;
        ctrl.wrregdsrc = 1'b1;
        ctrl.regdst    = is_imm_alu(op) ? rd_rt : rd_rd;
      end
      sEXE_BR: begin
        ctrl.pcwre = 1'b1;
        ctrl.pcsrc = taken ? pc_br : pc_seq;
      end
      sMEM: begin
        if (op == op_sw) begin
          ctrl.mwr   = 1'b1;
          ctrl.pcwre = 1'b1;
        end else if (op == op_lw) begin
          ctrl.mrd = 1'b1;
        end
      end
      sWB_L: begin
        ctrl.pcwre     = 1'b1;
        ctrl.regwre    = 1'b1;
        ctrl.dbdatasrc = 1'b1;
        ctrl.wrregdsrc = 1'b1;
        ctrl.regdst    = rd_rt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style controller: state register, next-state logic, reset gating of outputs.
// Macro MCC_ILLEGAL_TRAP_EN: unlisted opcodes hold the FSM in sID (like halt) until reset.
module multi_cycle_control
  import mcc_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               mRD,
  output logic               mWR,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic               ExtSel,
  output logic [1:0]         RegDst,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state
);

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cur_state <= sIF;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = sIF;
    case (cur_state)
      sIF: nxt_state = sID;
      sID: begin
        if (op == op_j || op == op_jal || op == op_jr)      nxt_state = sIF;
        else if (op == op_halt)                             nxt_state = sID;
        else if (op == op_beq || op == op_bne || op == op_bltz) nxt_state = sEXE_BR;
        else if (op == op_sw || op == op_lw)                nxt_state = sEXE_LS;
        else if (is_alu_op(op))                             nxt_state = sEXE_AL;
        else begin
`ifdef MCC_ILLEGAL_TRAP_EN
          nxt_state = sID;
`else
          nxt_state = sIF;
`endif
        end
      end
      sEXE_AL: nxt_state = sWB_AL;
      sEXE_LS: nxt_state = sMEM;
      sMEM:    nxt_state = (op == op_lw) ? sWB_L : sIF;
      default: nxt_state = sIF;
    endcase
  end

  mcc_output_decode u_decode (
    .state (cur_state),
    .op    (op),
    .zero  (zero),
    .sign  (sign),
    .ctrl  (dec)
  );

  // Reset masks the whole control word, including sIF's IR/imem strobes
  always_comb begin
    ctrl = Reset ? '0 : dec;
  end

  assign PCWre     = ctrl.pcwre;
  assign IRWre     = ctrl.irwre;
  assign InsMemRW  = ctrl.insmemrw;
  assign mRD       = ctrl.mrd;
  assign mWR       = ctrl.mwr;
  assign RegWre    = ctrl.regwre;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign DBDataSrc = ctrl.dbdatasrc;
  assign WrRegDSrc = ctrl.wrregdsrc;
  assign ExtSel    = ctrl.extsel;
  assign RegDst    = ctrl.regdst;
  assign PCSrc     = ctrl.pcsrc;
  assign ALUOp     = ALUOP_W'(ctrl.aluop);
  assign state     = cur_state;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: ALUOP_W, 3, width of the ALU operation select.
REQ-002 Port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 Port: Reset  input  1  asynchronous, active-high reset.
REQ-004 Port: op  input  6  opcode field from the instruction decode stage.
REQ-005 Port: zero, sign  input  1 each  ALU result-zero / result-negative flags from the EXE cycle.
REQ-006 Port: PCWre, IRWre, InsMemRW, mRD, mWR, RegWre  output  1 each  PC write, IR write, imem read, dmem read, dmem write, regfile write.
REQ-007 Port: ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel  output  1 each  shamt/rs, imm/rt, mem/ALU writeback, PC+4/DB writeback, sign/zero extend.
REQ-008 Port: RegDst, PCSrc  output  2 each  write-reg select (00 $31, 01 rt, 10 rd); next-PC select (00 PC+4, 01 branch, 10 jr, 11 j/jal).
REQ-009 Port: ALUOp  output  ALUOP_W  ALU function; state  output  3  current FSM state.

Function
REQ-010 States: sIF 000, sID 001, sEXE_AL 110, sWB_AL 111, sEXE_BR 101, sEXE_LS 010, sMEM 011, sWB_L 100; state register updates on CLK rising edge only.
REQ-011 Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, or 010011, sll 011000, slti 011100, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
REQ-012 sIF -> sID unconditionally; IRWre=1, InsMemRW=1 in sIF only.
REQ-013 sID: j/jal/jr -> sIF (PCWre=1 in sID; jal also RegWre=1, RegDst=00, WrRegDSrc=0); halt -> remain sID with PCWre=0 forever until reset; beq/bne/bltz -> sEXE_BR; sw/lw -> sEXE_LS; all other legal ops -> sEXE_AL.
REQ-014 sEXE_AL -> sWB_AL -> sIF; RegWre=1 and PCWre=1 in sWB_AL only; RegDst=01 for immediate ops, 10 for R-type.
REQ-015 sEXE_BR -> sIF with PCWre=1; PCSrc=01 when (beq&zero)|(bne&~zero)|(bltz&sign), else 00.
REQ-016 sEXE_LS -> sMEM; sMEM: sw -> sIF (mWR=1, PCWre=1); lw -> sWB_L (mRD=1); sWB_L -> sIF (RegWre=1, DBDataSrc=1, RegDst=01, PCWre=1).
REQ-017 PCWre asserted exactly once per instruction, in its final cycle; latency: R/I-ALU 4, branch 3, sw 4, lw 5, j/jal/jr 2 cycles.
REQ-018 ALUOp: add/addiu/lw/sw 000, sub/beq/bne/bltz 001, sll 100, or/ori 101, and/andi 110, slt/slti 011 (signed compare); ALUSrcA=1 only for sll; ALUSrcB=1 for addiu/andi/ori/slti/lw/sw; ExtSel=0 for andi/ori, else 1.
REQ-019 Outputs are combinational from (state, op, zero, sign); all write enables (PCWre, IRWre, RegWre, mWR) SHALL be 0 in any state not listed above for them.

Reset
REQ-020 Reset asserted (any time, including mid-instruction) forces state=sIF immediately; while Reset=1, PCWre=RegWre=mWR=mRD=0, IRWre=0, all other outputs 0.
REQ-021 First rising edge after Reset deasserts performs sIF -> sID.

Configuration
REQ-022 Macro MCC_ILLEGAL_TRAP_EN: defined -> unlisted opcode in sID holds the FSM in sID with all write enables 0 (same as halt) until reset.
REQ-023 Undefined -> unlisted opcode treated as NOP: sID -> sIF with PCWre=1, no other write enable.

Structure
REQ-024 Shared package mcc_pkg holds opcode constants, state encodings, ALUOp encodings, RegDst/PCSrc encodings.
REQ-025 One sub-module mcc_output_decode: combinational (state, op, zero, sign) -> control outputs; top holds state register and next-state logic.

Verification
REQ-026 Reset mid-sMEM during sw -> state=000 same cycle, mWR=0; next edge state=001.
REQ-027 op=000000 stream -> states 000,001,110,111,000; RegWre=1, RegDst=10 only in 111; PCWre high once.
REQ-028 op=110100, zero=1 -> sEXE_BR PCSrc=01, PCWre=1; zero=0 -> PCSrc=00.
REQ-029 op=110001 -> 000,001,010,011(mRD=1),100(RegWre=1, DBDataSrc=1),000.
REQ-030 op=111010 -> sID with PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; op=111111 -> stays 001, PCWre=0 for 10 cycles.
REQ-031 op=101010 with/without MCC_ILLEGAL_TRAP_EN -> stays 001 / returns 000 with PCWre=1.
